// File: rtl/spi_reg_pkg.sv
// Shared types and command-byte field constants for the SPI register controller.
package spi_reg_pkg;

  localparam int unsigned DEF_ADDR_W    = 3;
  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned CMD_W         = 8;
  localparam int unsigned CMD_WRITE_BIT = 7;
  localparam int unsigned CMD_RSVD_MSB  = 6;

  // Bits below the write flag; the address field is carved out of these.
  localparam logic [7:0] CMD_FIELD_MASK = 8'h7F;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    WAIT_CS
  } state_e;

  // Command bits that must be zero for a given address width.
  function automatic logic [7:0] cmd_rsvd_mask(input int unsigned addr_w);
    return CMD_FIELD_MASK & ~8'((32'd1 << addr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Register-bus side of the SPI controller: write strobe, read request, read data.
interface spi_reg_ctrl_if #(
  parameter int unsigned ADDR_W = spi_reg_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = spi_reg_pkg::DEF_DATA_W
);

  logic              reg_wr_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_rd_en;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    output reg_wr_en,
    output reg_addr,
    output reg_wdata,
    output reg_rd_en,
    input  reg_rdata
  );

  modport slave (
    input  reg_wr_en,
    input  reg_addr,
    input  reg_wdata,
    input  reg_rd_en,
    output reg_rdata
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered level and rise/fall pulses.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl_q, lvl_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    lvl_d  = sync_q[SYNC_STAGES-1];
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      lvl_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Oversampled SPI mode-0 slave that frames command+data transfers into
// single-cycle register write strobes and read requests.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  sdi,
  output logic                  sdo,
  spi_reg_ctrl_if.master        bus,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned SETTLE = SYNC_STAGES + 1;
  localparam int unsigned SET_W  = $clog2(SETTLE + 1);
  localparam logic [7:0]  RSVD_MASK = cmd_rsvd_mask(ADDR_W);

  logic sck_rise, sck_fall, sck_lvl_unused;
  logic cs_rise, cs_fall, cs_lvl;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .din  (sck),
    .lvl  (sck_lvl_unused),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .din  (cs_n),
    .lvl  (cs_lvl),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // sdi gets one extra stage so its sample lines up with the registered sck pulse.
  logic [SYNC_STAGES:0] sdi_q, sdi_d;
  logic                 sdi_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              err_q, err_d;
  logic              ld_pend_q, ld_pend_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              tx_act_q, tx_act_d;
  logic              sdo_q, sdo_d;
  logic              armed_q, armed_d;
  logic [SET_W-1:0]  settle_q, settle_d;

  logic [DATA_W-1:0] shift_in;
  logic [7:0]        cmd_byte;
  logic [DATA_W-1:0] tx_cur;
  logic [CNT_W-1:0]  cnt_cur;
  logic              act_cur;
  logic              settle_done;

  assign sdi_s = sdi_q[SYNC_STAGES];

  always_comb begin
    sdi_d       = {sdi_q[SYNC_STAGES-1:0], sdi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    err_d       = 1'b0;
    ld_pend_d   = rd_en_q;
    sdo_d       = sdo_q;
    shift_in    = {shift_q, sdi_s};
    cmd_byte    = shift_in[7:0];

    // Arm only once the cs synchronizer has flushed and seen cs_n high,
    // so a frame already running at reset release is never picked up.
    settle_done = (settle_q == SET_W'(SETTLE));
    settle_d    = settle_done ? settle_q : settle_q + SET_W'(1);
    armed_d     = armed_q | (settle_done & cs_lvl);

    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d   = CMD;
          bit_cnt_d = '0;
        end
      end
      CMD: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sck_rise) begin
          shift_d   = shift_in[DATA_W-2:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
            bit_cnt_d = '0;
            if ((cmd_byte & RSVD_MASK) != 8'h00) begin
              err_d   = 1'b1;
              state_d = WAIT_CS;
            end else begin
              addr_d  = cmd_byte[ADDR_W-1:0];
              is_wr_d = cmd_byte[CMD_WRITE_BIT];
              rd_en_d = ~cmd_byte[CMD_WRITE_BIT];
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        // A cs_n rise in the same cycle as the last sck rise is an abort.
        if (cs_rise) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sck_rise) begin
          shift_d   = shift_in[DATA_W-2:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = WAIT_CS;
            if (is_wr_q) begin
              wdata_d = shift_in;
              wr_en_d = 1'b1;
            end
          end
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data arrives one cycle after the request; it may coincide with the first sck fall.
    tx_cur   = ld_pend_q ? bus.reg_rdata : tx_q;
    cnt_cur  = ld_pend_q ? '0 : tx_cnt_q;
    act_cur  = ld_pend_q | tx_act_q;
    tx_d     = tx_cur;
    tx_cnt_d = cnt_cur;
    tx_act_d = act_cur;
    if (sck_fall && act_cur) begin
      if (cnt_cur == CNT_W'(DATA_W)) begin
        sdo_d    = 1'b0;
        tx_act_d = 1'b0;
      end else begin
        sdo_d    = tx_cur[DATA_W-1];
        tx_d     = {tx_cur[DATA_W-2:0], 1'b0};
        tx_cnt_d = cnt_cur + CNT_W'(1);
      end
    end
    if (state_d == IDLE || state_d == CMD) begin
      sdo_d    = 1'b0;
      tx_act_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdi_q     <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      err_q     <= 1'b0;
      ld_pend_q <= 1'b0;
      tx_q      <= '0;
      tx_cnt_q  <= '0;
      tx_act_q  <= 1'b0;
      sdo_q     <= 1'b0;
      armed_q   <= 1'b0;
      settle_q  <= '0;
    end else begin
      sdi_q     <= sdi_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      err_q     <= err_d;
      ld_pend_q <= ld_pend_d;
      tx_q      <= tx_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_act_q  <= tx_act_d;
      sdo_q     <= sdo_d;
      armed_q   <= armed_d;
      settle_q  <= settle_d;
    end
  end

  assign sdo           = sdo_q;
  assign bus.reg_wr_en = wr_en_q;
  assign bus.reg_rd_en = rd_en_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign frame_err     = err_q;
  // Mirrors the synchronized chip select; the cs flops reset high so busy resets low.
  assign busy          = ~cs_lvl;

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

System-clock-domain SPI slave controller that sequences register-level transactions from the MCU into the FPGA core. It oversamples the raw SPI pins (sck, cs_n, sdi), frames each transfer into a command byte plus a data word, and issues single-cycle write strobes or read requests on a simple register bus. It sits between the top-level SPI pins and the core's configuration/status register file. It replaces free-running shifting on sck with a clocked, error-checked protocol.

## Interface
Parameters:
- ADDR_W, 3: register address width; legal addresses are 0..2^ADDR_W-1.
- DATA_W, 16: register data width; must be a multiple of 8.
- SYNC_STAGES, 2: flop stages in each input synchronizer; minimum 2.

Ports:
- clk  in  1  system clock; all state on posedge clk.
- reset_n  in  1  asynchronous, active-low reset.
- sck  in  1  raw SPI clock, mode 0 (cpol=0, cpha=0), asynchronous to clk.
- cs_n  in  1  raw active-low chip select.
- sdi  in  1  raw MOSI.
- sdo  out  1  MISO, registered.
- reg_wr_en  out  1  single-cycle write strobe.
- reg_addr  out  ADDR_W  address for write strobe and read request.
- reg_wdata  out  DATA_W  write data, valid with reg_wr_en.
- reg_rd_en  out  1  single-cycle read request.
- reg_rdata  in  DATA_W  read data, sampled 1 clk after reg_rd_en.
- busy  out  1  high while a frame is in progress (cs_n low, synchronized).
- frame_err  out  1  single-cycle pulse on a malformed or aborted frame.

## Operation
- Frame, MSB first: command byte, then DATA_W/8 data bytes.
  - Command byte: bit7 = 1 write, 0 read. Bits 6:ADDR_W must be 0. Bits ADDR_W-1:0 are the address.
- FSM states: IDLE, CMD, DATA, WAIT_CS.
  - IDLE -> CMD on synchronized cs_n falling edge. Bit counter clears.
  - CMD: shift sdi in on each detected sck rising edge. After the 8th bit:
    - Reserved bits nonzero: pulse frame_err and go to WAIT_CS.
    - Otherwise latch reg_addr. On a read, pulse reg_rd_en. Go to DATA.
  - DATA: shift DATA_W bits in.
    - Write, after the last bit: reg_wdata <= shifted word, pulse reg_wr_en, go to WAIT_CS.
    - Read: sdi bits are ignored. Go to WAIT_CS after DATA_W bits.
  - WAIT_CS: additional sck edges are ignored, with no error. Go to IDLE on cs_n rising edge.
- cs_n rising edge in CMD or DATA: abort. Pulse frame_err, issue no strobe, go to IDLE.
- Read path: on the clk after reg_rd_en, load reg_rdata into the output shifter.
  - Update sdo on each detected sck falling edge. The first falling edge after the 8th rising edge presents bit DATA_W-1.
- sdo is 0 in IDLE, in CMD, and after the last read bit.
- Reset values: sdo 0, reg_wr_en 0, reg_rd_en 0, reg_addr 0, reg_wdata 0, busy 0, frame_err 0, FSM IDLE.
- Assertion of reset_n mid-frame returns the block to IDLE with no strobe. A frame already in progress after reset release is not recognized until the next cs_n falling edge.

## Timing
- Requirement: f_clk ≥ 4·f_sck, and cs_n setup to the first sck edge ≥ 2 sck half-periods.
- Edge detect latency: SYNC_STAGES+1 clk from a pin transition to the internal edge pulse.
- reg_wr_en asserts 1 clk after the detected last rising edge. reg_addr and reg_wdata are stable from that cycle until the next frame's command completes.
- reg_rd_en asserts 1 clk after the detected 8th rising edge. reg_rdata must be valid on the following clk. The sdo MSB is driven at the next detected falling edge, which is ≥ 2 clk later.
- busy follows synchronized cs_n with the same latency as edge detect.
- Simultaneous events: a cs_n rising edge detected in the same clk as the final sck rising edge counts as an abort. No strobe is issued and frame_err pulses.

## Structure
- Package spi_reg_pkg holds:
  - state enum type (IDLE, CMD, DATA, WAIT_CS);
  - CMD_WRITE_BIT = 7;
  - default ADDR_W and DATA_W localparams;
  - command-byte field helper constants.
- Sub-module spi_sync_edge: SYNC_STAGES-flop synchronizer plus rise/fall pulse outputs. It is instantiated for sck and cs_n. sdi uses the synchronizer path only, so its alignment matches sck.

## Test plan
- Write: cs_n low, shift 0x85 then 0xBEEF, cs_n high -> exactly one reg_wr_en pulse with reg_addr=5, reg_wdata=0xBEEF; frame_err stays 0.
- Read: reg_rdata model returns 0x1234 for addr 2; shift 0x02 plus 16 dummy bits -> one reg_rd_en with reg_addr=2; sdo sampled on sck rising edges reads 0x1234; no write strobe.
- Reserved bits: command 0xC1 -> frame_err pulse after bit 8; no rd/wr strobe; extra 16 sck cycles ignored; IDLE after cs_n rises.
- Abort: command 0x83 plus 10 data bits, then cs_n high -> frame_err pulse, no reg_wr_en, busy drops; a following valid write 0x83/0x00FF succeeds.
- Reset mid-frame: assert reset_n low during the data bits of a write -> all outputs at reset values; after release, a new full frame 0x81/0xA5A5 writes addr 1 = 0xA5A5.
- Rate limit: f_sck = f_clk/4 back-to-back frames, a write then a read with cs_n high for 4 clk between them -> both complete correctly.
